// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: opcode/funct3 constants, control encodings, states and instruction classifier
package risc_ctrl_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
    typedef enum logic [2:0] {C_BAD, C_LOAD, C_STORE, C_R, C_I, C_BR} cls_t;
    // C_BAD covers every opcode/funct3 pair the datapath cannot execute
    function automatic cls_t classify(input logic [6:0] opcode, input logic [2:0] f3);
        logic alu_ok;
        alu_ok = f3 == F3_ADD || f3 == F3_SLT || f3 == F3_OR || f3 == F3_AND;
        return (opcode == OP_LOAD && f3 == F3_W) ? C_LOAD :
               (opcode == OP_STORE && f3 == F3_W) ? C_STORE :
               (opcode == OP_R && alu_ok) ? C_R :
               (opcode == OP_I && alu_ok) ? C_I :
               (opcode == OP_BR && (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT)) ? C_BR : C_BAD;
    endfunction
endpackage

// File: rtl/risc_multicycle_ctrl_alu_decoder.sv
// alu_decoder: instruction class, funct3 and Instr[30] to ALUControl
module alu_decoder import risc_ctrl_pkg::*; (
    input  cls_t       cls,
    input  logic [2:0] funct3,
    input  logic       instr30,
    output logic [2:0] alu_control
);
    wire alu_op = cls == C_R || cls == C_I;
    assign alu_control = cls == C_BR ? ALU_SUB :
                         !alu_op ? ALU_ADD :
                         funct3 == F3_SLT ? ALU_SLT :
                         funct3 == F3_OR ? ALU_OR :
                         funct3 == F3_AND ? ALU_AND :
                         (cls == C_R && instr30) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/risc_multicycle_ctrl.sv
// risc_multicycle_ctrl: FETCH/DECODE/EXEC/MEM sequencer driving the RISC-V datapath controls
module risc_multicycle_ctrl import risc_ctrl_pkg::*; #(
    parameter int FETCH_WAIT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [10:0]      op_func,
    input  logic             ZF,
    input  logic             SF,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] retired
);
    localparam int FW = FETCH_WAIT > 1 ? $clog2(FETCH_WAIT) : 1;
    state_t state, state_n;
    logic [FW-1:0] fcnt;
    logic [10:0] op_q;
    logic illegal_q;
    logic [CNT_W-1:0] cnt;
    logic [2:0] alu_ctl;
    cls_t cls;
    wire fetch_done = fcnt == FW'(FETCH_WAIT - 1);
    wire active = state == S_DECODE || state == S_EXEC || state == S_MEM;
    wire exec = state == S_EXEC;
    wire mem = state == S_MEM;
    assign cls = classify(op_q[6:0], op_q[9:7]);
    alu_decoder u_alu_dec (.cls(cls), .funct3(op_q[9:7]), .instr30(op_q[10]), .alu_control(alu_ctl));
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= S_FETCH;
            fcnt      <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            fcnt  <= (state == S_FETCH && !fetch_done) ? fcnt + 1'b1 : '0;
            // capture on the edge into DECODE so op_q is valid for the whole instruction
            if (state == S_FETCH && fetch_done)
                op_q <= op_func;
            if (state == S_DECODE && cls == C_BAD)
                illegal_q <= 1'b1;
            if (PCWrite)
                cnt <= cnt + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  state_n = fetch_done ? S_DECODE : S_FETCH;
            S_DECODE: state_n = cls == C_BAD ? S_HALT : S_EXEC;
            S_EXEC:   state_n = cls == C_LOAD ? S_MEM : S_FETCH;
            S_MEM:    state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_FETCH;
        endcase
    end
    assign ALUSrc     = active && (cls == C_LOAD || cls == C_STORE || cls == C_I);
    assign ALUControl = active ? alu_ctl : ALU_ADD;
    assign ImmSrc     = !active ? IMM_I : cls == C_STORE ? IMM_S : cls == C_BR ? IMM_B : IMM_I;
    assign ResultSrc  = active && cls == C_LOAD;
    assign PCWrite    = !rst && ((exec && cls != C_LOAD) || mem);
    assign RegWrite   = !rst && ((exec && (cls == C_R || cls == C_I)) || mem);
    assign MemWrite   = !rst && exec && cls == C_STORE;
    assign PCSrc      = exec && cls == C_BR &&
                        (op_q[9:7] == F3_BEQ ? ZF : op_q[9:7] == F3_BNE ? !ZF : SF);
    assign Illegal    = illegal_q;
    assign retired    = cnt;
endmodule

// File: doc/risc_multicycle_ctrl.md
# risc_multicycle_ctrl

Multicycle control sequencer for the RISC-V datapath. It consumes `op_func` = {Instr[30], funct3, opcode}, `ZF` and `SF` from the datapath. It drives every datapath control input, plus a new `PCWrite` enable for the PC register. Each instruction is split into FETCH/DECODE/EXEC(/MEM) phases, so that write strobes fire exactly once per instruction and the instruction memory may need more than one cycle.

## Interface
- `FETCH_WAIT`, default 1: cycles spent in FETCH (≥1) before `op_func` is sampled.
- `CNT_W`, default 32: width of retired-instruction counter.

Clock and reset: one clock; reset is synchronous and active-high (`CLK`, `rst`).

- `CLK`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `op_func`  in  11  {Instr[30], Instr[14:12], Instr[6:0]}.
- `ZF`  in  1  ALU zero flag.
- `SF`  in  1  ALU sign flag.
- `PCWrite`  out  1  PC register load enable (one pulse per instruction).
- `PCSrc`  out  1  0 = PC+4, 1 = PCTarget.
- `RegWrite`  out  1  register file write enable.
- `ALUSrc`  out  1  0 = RD2, 1 = ImmExt.
- `MemWrite`  out  1  data memory write enable.
- `ResultSrc`  out  1  0 = ALUResult, 1 = ReadData.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  2  00 I, 01 S, 10 B.
- `Illegal`  out  1  sticky: unsupported instruction decoded.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation

**Supported instructions**
- lw: 0000011, f3 010.
- sw: 0100011, f3 010.
- R-type: 0110011 — add/sub f3 000 (Instr[30] selects sub), slt 010, or 110, and 111.
- I-ALU: 0010011 — addi 000, slti 010, ori 110, andi 111; Instr[30] ignored.
- Branches: 1100011 — beq 000, bne 001, blt 100.
- Anything else is illegal.

**States**
- FETCH: waits `FETCH_WAIT` cycles (counter), then goes to DECODE.
- DECODE: latches `op_func` into `op_q`. Illegal → HALT, otherwise → EXEC.
- EXEC: ALU/immediate controls decoded from `op_q`.
  - R/I-ALU: `RegWrite`=1, `PCWrite`=1 → FETCH.
  - sw: `ALUSrc`=1, `ImmSrc`=01, `MemWrite`=1, `PCWrite`=1 → FETCH.
  - lw: `ALUSrc`=1, add → MEM (no strobes).
  - Branch: `ALUControl`=sub, `ImmSrc`=10, `PCWrite`=1. `PCSrc` is taken from live flags: beq→ZF, bne→!ZF, blt→SF. → FETCH.
- MEM: lw address controls held; `ResultSrc`=1, `RegWrite`=1, `PCWrite`=1 → FETCH.
- HALT: all strobes 0, `Illegal`=1. Exit only via `rst`.

**Output rules**
- Non-strobe controls (`ALUSrc`, `ALUControl`, `ImmSrc`, `ResultSrc`) are decoded from `op_q` and held constant in DECODE/EXEC/MEM.
- All outputs are 0 in FETCH and HALT.
- `retired` increments on every `PCWrite` pulse and wraps modulo 2^`CNT_W`.

## Timing
- Outputs are combinational from state and `op_q`; there are no input-to-strobe paths except branch `PCSrc` from `ZF`/`SF`.
- Latency with W = `FETCH_WAIT`:
  - ALU, sw, branch: W+2 cycles.
  - lw: W+3 cycles.
- Exactly one `PCWrite` cycle per instruction. `RegWrite` and `MemWrite` are never both high.
- Reset values:
  - state FETCH, fetch counter 0, `op_q` 0, `retired` 0, `Illegal` 0.
  - While `rst`=1, all strobes (`PCWrite`, `RegWrite`, `MemWrite`) are forced 0, even if state is EXEC/MEM.
- Reset mid-instruction: no strobe fires in the reset cycle; FETCH begins on the cycle after `rst` falls.
- `op_func` is sampled only at the DECODE edge; later changes are ignored until the next DECODE.

## Structure
- Package `risc_ctrl_pkg`: opcode constants, funct3 constants, `ALUControl` and `ImmSrc` encodings, state enum.
- One combinational sub-module `alu_decoder`: (opcode class, funct3, Instr[30]) → `ALUControl`.
- Main decoder and FSM live in the top module.

## Test plan
- addi x1,x0,5 (op_func 0_000_0010011), W=1: `RegWrite`/`PCWrite` high in cycle 3 only; `ALUSrc`=1, `ALUControl`=000; `retired`=1.
- sub (1_000_0110011) then and (0_111_0110011): `ALUControl` 001 then 010, `ALUSrc`=0; `retired`=2 after 6 cycles.
- lw (0_010_0000011): EXEC has no strobes; MEM has `ResultSrc`=1, `RegWrite`=1, `PCWrite`=1; 4 cycles total. sw (0_010_0100011): `MemWrite`=1, `ImmSrc`=01 in cycle 3.
- beq with ZF=1 → `PCSrc`=1. bne with ZF=1 → `PCSrc`=0. blt with SF=1 → `PCSrc`=1. `ImmSrc`=10 and `RegWrite`=0 in all cases.
- op_func 0_000_0110111 (lui): HALT, `Illegal`=1, no strobes for 20 cycles; `rst` clears `Illegal` and restarts in FETCH.
- `FETCH_WAIT`=3 with `rst` asserted during lw MEM: no `RegWrite` in the reset cycle; next addi completes in 5 cycles with `retired`=1.
